result_streamer: RTL and testbench



---
 rtl/result_streamer_pkg.sv | 12 +
 rtl/stream_skid_fifo.sv | 67 ++++++
 rtl/result_streamer.sv | 152 +++++++++++++++
 tb/tb_result_streamer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/result_streamer_pkg.sv
// Shared definitions for result_streamer: FSM state encoding and stream data width.
package result_streamer_pkg;

   localparam int AXIS_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry ordered buffer that absorbs downstream backpressure in result_streamer.
// Entry 0 is always the head; flush empties the buffer without touching the data.
module stream_skid_fifo #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [width-1:0] din,
   output logic [width-1:0] head,
   output logic [1:0]       occ
);

   logic [width-1:0] ent0_r;
   logic [width-1:0] ent1_r;
   logic [1:0]       occ_r;

   // Storage and occupancy update; pops shift entry 1 toward the head.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ent0_r <= {width{1'b0}};
         ent1_r <= {width{1'b0}};
         occ_r  <= 2'd0;
      end else if (flush) begin
         occ_r  <= 2'd0;
      end else begin
         case ({push, pop})
            2'b11: begin
               if (occ_r == 2'd2) begin
                  ent0_r <= ent1_r;
                  ent1_r <= din;
               end else begin
                  ent0_r <= din;
               end
            end
            2'b10: begin
               if (occ_r == 2'd0) begin
                  ent0_r <= din;
                  occ_r  <= 2'd1;
               end else if (occ_r == 2'd1) begin
                  ent1_r <= din;
                  occ_r  <= 2'd2;
               end else begin
                  occ_r  <= occ_r;
               end
            end
            2'b01: begin
               if (occ_r != 2'd0) begin
                  ent0_r <= ent1_r;
                  occ_r  <= occ_r - 2'd1;
               end else begin
                  occ_r  <= occ_r;
               end
            end
            default: begin
               occ_r <= occ_r;
            end
         endcase
      end
   end

   assign head = ent0_r;
   assign occ  = occ_r;

endmodule

// File: rtl/result_streamer.sv
// Streams the result RAM out as an AXI4-Stream master, one beat per cycle when unstalled.
// Build option: RESULT_STREAMER_SIGN_EXT_EN sign-extends TDATA instead of zero-extending it.
module result_streamer
   import result_streamer_pkg::*;
#(
   parameter int width      = 8,
   parameter int depth_bits = 7,
   parameter int NUM_WORDS  = 128
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   Start,
   output logic                   Done,
   output logic                   RES_read_en,
   output logic [depth_bits-1:0]  RES_read_address,
   input  logic [width-1:0]       RES_read_data_out,
   output logic                   M_AXIS_TVALID,
   input  logic                   M_AXIS_TREADY,
   output logic [AXIS_DATA_W-1:0] M_AXIS_TDATA,
   output logic                   M_AXIS_TLAST
);

   localparam int                    CNT_W      = depth_bits + 1;
   localparam logic [CNT_W-1:0]      WORDS_C    = CNT_W'(NUM_WORDS);
   localparam logic [depth_bits-1:0] LAST_IDX_C = depth_bits'(NUM_WORDS - 1);

   state_e                state_r;
   state_e                state_s;
   logic [CNT_W-1:0]      rd_addr_r;
   logic [depth_bits-1:0] out_idx_r;
   logic                  inflight_r;

   logic [1:0]            occ_s;
   logic [width-1:0]      head_s;
   logic [2:0]            pending_s;
   logic                  streaming_s;
   logic                  done_s;
   logic                  issue_s;
   logic                  pop_s;
   logic                  tvalid_s;
   logic                  tlast_s;
   logic                  flush_s;
   logic                  clear_s;

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next state; dropping Start returns to IDLE from anywhere.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (Start) state_s = ST_STREAM;
            else       state_s = ST_IDLE;
         end
         ST_STREAM: begin
            if (!Start)                          state_s = ST_IDLE;
            else if (pop_s && tlast_s)           state_s = ST_DONE;
            else                                 state_s = ST_STREAM;
         end
         ST_DONE: begin
            if (!Start) state_s = ST_IDLE;
            else        state_s = ST_DONE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM output decode.
   always_comb begin
      streaming_s = 1'b0;
      done_s      = 1'b0;
      case (state_r)
         ST_STREAM: streaming_s = 1'b1;
         ST_DONE:   done_s      = 1'b1;
         default: begin
            streaming_s = 1'b0;
            done_s      = 1'b0;
         end
      endcase
   end

   assign tvalid_s  = (occ_s != 2'd0);
   assign tlast_s   = tvalid_s && (out_idx_r == LAST_IDX_C);
   assign pop_s     = tvalid_s && M_AXIS_TREADY;
   assign flush_s   = (state_r != ST_IDLE) && !Start;
   assign clear_s   = (state_s == ST_IDLE);

   // A read is only issued if its data is guaranteed a buffer slot on arrival.
   assign pending_s = {1'b0, occ_s} + {2'b00, inflight_r};
   assign issue_s   = streaming_s && (rd_addr_r < WORDS_C) &&
                      (pending_s < (3'd2 + {2'b00, pop_s}));

   // Read and beat counters plus the in-flight read flag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_addr_r  <= {CNT_W{1'b0}};
         out_idx_r  <= {depth_bits{1'b0}};
         inflight_r <= 1'b0;
      end else if (clear_s) begin
         rd_addr_r  <= {CNT_W{1'b0}};
         out_idx_r  <= {depth_bits{1'b0}};
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= issue_s;
         if (issue_s) begin
            rd_addr_r <= rd_addr_r + CNT_W'(1'b1);
         end else begin
            rd_addr_r <= rd_addr_r;
         end
         if (pop_s && (out_idx_r != LAST_IDX_C)) begin
            out_idx_r <= out_idx_r + depth_bits'(1'b1);
         end else begin
            out_idx_r <= out_idx_r;
         end
      end
   end

   stream_skid_fifo #(
      .width (width)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush_s),
      .push   (inflight_r),
      .pop    (pop_s),
      .din    (RES_read_data_out),
      .head   (head_s),
      .occ    (occ_s)
   );

   assign Done             = done_s;
   assign RES_read_en      = issue_s;
   assign RES_read_address = rd_addr_r[depth_bits-1:0];
   assign M_AXIS_TVALID    = tvalid_s;
   assign M_AXIS_TLAST     = tlast_s;

`ifdef RESULT_STREAMER_SIGN_EXT_EN
   assign M_AXIS_TDATA = {{(AXIS_DATA_W - width){head_s[width-1]}}, head_s};
`else
   assign M_AXIS_TDATA = {{(AXIS_DATA_W - width){1'b0}}, head_s};
`endif

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer: RAM model, per-cycle stream scoreboard,
// and directed scenarios with hand-computed latency and data expectations.
module tb_result_streamer;

   logic        clk;
   logic        resetn;
   logic        Start;
   logic        Done;
   logic        RES_read_en;
   logic [6:0]  RES_read_address;
   logic [7:0]  RES_read_data_out;
   logic        M_AXIS_TVALID;
   logic        M_AXIS_TREADY;
   logic [31:0] M_AXIS_TDATA;
   logic        M_AXIS_TLAST;

   logic [7:0]  ram [128];
   int          errors;
   int          checks;
   int          exp_idx;
   int          reads_m;
   bit          done_m;

   result_streamer dut (
      .clk               (clk),
      .resetn            (resetn),
      .Start             (Start),
      .Done              (Done),
      .RES_read_en       (RES_read_en),
      .RES_read_address  (RES_read_address),
      .RES_read_data_out (RES_read_data_out),
      .M_AXIS_TVALID     (M_AXIS_TVALID),
      .M_AXIS_TREADY     (M_AXIS_TREADY),
      .M_AXIS_TDATA      (M_AXIS_TDATA),
      .M_AXIS_TLAST      (M_AXIS_TLAST)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM with one-cycle read latency.
   always @(posedge clk) begin
      if (RES_read_en) RES_read_data_out <= ram[RES_read_address];
   end

   function automatic logic [31:0] ext(input logic [7:0] v);
`ifdef RESULT_STREAMER_SIGN_EXT_EN
      return {{24{v[7]}}, v};
`else
      return {24'd0, v};
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: beat k of a run must carry ext(ram[k]); reads must be in order and bounded.
   initial begin
      exp_idx = 0;
      reads_m = 0;
      done_m  = 1'b0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            exp_idx = 0;
            reads_m = 0;
            done_m  = 1'b0;
         end else begin
            chk("done", Done, done_m);
            if (M_AXIS_TVALID) begin
               if (exp_idx < 128) begin
                  chk("tdata", M_AXIS_TDATA, ext(ram[exp_idx]));
                  chk("tlast", M_AXIS_TLAST, (exp_idx == 127));
               end else begin
                  chk("extra_beat", 32'd1, 32'd0);
               end
            end else begin
               chk("tlast_idle", M_AXIS_TLAST, 1'b0);
            end
            if (done_m) chk("tvalid_after_done", M_AXIS_TVALID, 1'b0);
            if (RES_read_en) begin
               chk("rd_addr", RES_read_address, reads_m);
               chk("rd_bound", (reads_m < 128), 1'b1);
               reads_m++;
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
               if (exp_idx == 127) done_m = 1'b1;
               exp_idx++;
            end
            chk("outstanding", ((reads_m - exp_idx) <= 2), 1'b1);
            if (!Start) begin
               exp_idx = 0;
               reads_m = 0;
               done_m  = 1'b0;
            end
         end
      end
   end

   task automatic wait_done(input string name, input int budget);
      int cyc;
      cyc = 0;
      while (!Done && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk(name, Done, 1'b1);
   endtask

   // One idle cycle so the DUT returns to IDLE and the model restarts.
   task automatic idle_cycle();
      Start = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int rc;
      int cyc;
      errors = 0;
      checks = 0;
      resetn = 1'b0;
      Start  = 1'b0;
      M_AXIS_TREADY = 1'b0;
      for (int i = 0; i < 128; i++) ram[i] = 8'(i);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_done",   Done, 1'b0);
      chk("rst_rd_en",  RES_read_en, 1'b0);
      chk("rst_addr",   RES_read_address, 7'd0);
      chk("rst_tvalid", M_AXIS_TVALID, 1'b0);
      chk("rst_tlast",  M_AXIS_TLAST, 1'b0);
      chk("rst_tdata",  M_AXIS_TDATA, 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // Full run, TREADY held high, RAM[i]=i.
      M_AXIS_TREADY = 1'b1;
      Start = 1'b1;
      @(posedge clk);
      @(posedge clk); @(negedge clk);
      chk("t1_tvalid_e1", M_AXIS_TVALID, 1'b0);
      @(posedge clk); @(negedge clk);
      chk("t1_tvalid_e2", M_AXIS_TVALID, 1'b1);
      chk("t1_first",     M_AXIS_TDATA, 32'd0);
      repeat (127) @(posedge clk);
      @(negedge clk);
      chk("t1_last_tlast", M_AXIS_TLAST, 1'b1);
      chk("t1_last_data",  M_AXIS_TDATA, 32'd127);
      chk("t1_last_done",  Done, 1'b0);
      @(posedge clk); @(negedge clk);
      chk("t1_done",       Done, 1'b1);
      chk("t1_tvalid_off", M_AXIS_TVALID, 1'b0);

      // Immediate restart with TREADY pattern 1,0,0 and RAM[i]=255-i.
      @(posedge clk); #1;
      for (int i = 0; i < 128; i++) ram[i] = 8'(255 - i);
      idle_cycle();
      Start = 1'b1;
      cyc = 0;
      while (!Done && cyc < 1000) begin
         M_AXIS_TREADY = ((cyc % 3) == 0);
         @(posedge clk); #1;
         cyc++;
      end
      chk("t2_done",  Done, 1'b1);
      chk("t2_beats", exp_idx, 128);
      idle_cycle();

      // Stall at start: only two reads may be issued.
      M_AXIS_TREADY = 1'b0;
      Start = 1'b1;
      rc = 0;
      repeat (10) begin
         @(negedge clk);
         if (RES_read_en) rc++;
      end
      chk("t3_reads",  rc, 2);
      chk("t3_tvalid", M_AXIS_TVALID, 1'b1);
      chk("t3_tdata",  M_AXIS_TDATA, 32'd255);
      @(posedge clk); #1;
      M_AXIS_TREADY = 1'b1;
      wait_done("t3_done", 400);
      idle_cycle();

      // Abort after beat 40, then restart with RAM[0]=0x80.
      for (int i = 0; i < 128; i++) ram[i] = 8'(i);
      ram[0] = 8'h80;
      Start = 1'b1;
      cyc = 0;
      while (exp_idx < 41 && cyc < 500) begin
         @(posedge clk);
         cyc++;
      end
      chk("t4_reach40", (exp_idx >= 41), 1'b1);
      #1;
      Start = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("t4_tvalid_drop", M_AXIS_TVALID, 1'b0);
      chk("t4_done_low",    Done, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      Start = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk); @(negedge clk);
      chk("t4_restart_tvalid", M_AXIS_TVALID, 1'b1);
`ifdef RESULT_STREAMER_SIGN_EXT_EN
      chk("t4_ext_0x80", M_AXIS_TDATA, 32'hFFFFFF80);
`else
      chk("t4_ext_0x80", M_AXIS_TDATA, 32'h00000080);
`endif
      wait_done("t4_done", 400);
      idle_cycle();

      // Asynchronous reset in the middle of a run.
      Start = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      resetn = 1'b0;
      Start  = 1'b0;
      #1;
      chk("t6_done",   Done, 1'b0);
      chk("t6_rd_en",  RES_read_en, 1'b0);
      chk("t6_addr",   RES_read_address, 7'd0);
      chk("t6_tvalid", M_AXIS_TVALID, 1'b0);
      chk("t6_tlast",  M_AXIS_TLAST, 1'b0);
      chk("t6_tdata",  M_AXIS_TDATA, 32'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t6_idle_tvalid", M_AXIS_TVALID, 1'b0);
      chk("t6_idle_rd_en",  RES_read_en, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
